// File: rtl/risc_sequencer.sv
// risc_sequencer: instruction-phase sequencer for the 8-bit accumulator CPU.
// Owns the 3-bit phase counter and decodes phase/opcode/zero into datapath strobes.
// Adds memory wait-state stalls with timeout, halt/resume, a retired-instruction
// counter and (with SEQ_STEP_EN defined) single-step pausing.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   start            pulse; leaves IDLE/HALT/PAUSE and restarts at phase 0
//   opcode, zero     IR opcode and accumulator-zero flag
//   mem_ready        memory read data valid (checked in phase 1 and ALU phase 5)
//   step_mode        pause after each instruction (SEQ_STEP_EN only)
//   sel..data_e      datapath strobes, combinational from state/phase/opcode/zero
//   halt             halting (phase 4 of HLT) or halted
//   phase            current phase
//   timeout          sticky memory-timeout flag
//   instr_cnt        retired instruction count (wraps)
module risc_sequencer #(
    parameter int unsigned WAIT_W   = 4,
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
`ifdef SEQ_STEP_EN
    input  logic             step_mode,
`endif
    output logic             sel,
    output logic             rd,
    output logic             ld_ir,
    output logic             inc_pc,
    output logic             ld_ac,
    output logic             wr,
    output logic             ld_pc,
    output logic             data_e,
    output logic             halt,
    output logic [2:0]       phase,
    output logic             timeout,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

`ifdef SEQ_STEP_EN
    typedef enum logic [1:0] {IDLE, RUN, HALT, PAUSE} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
`endif

    state_t              state_q, state_d;
    logic [2:0]          phase_q, phase_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                timeout_q, timeout_d;
    logic                aluop;
    logic                stall_phase;

    assign phase     = phase_q;
    assign timeout   = timeout_q;
    assign instr_cnt = cnt_q;

    // ADD, AND, XOR and LDA read an operand from memory in the execute phases
    assign aluop       = (opcode >= OP_ADD) && (opcode <= OP_LDA);
    assign stall_phase = (phase_q == 3'd1) || ((phase_q == 3'd5) && aluop);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            phase_q   <= 3'd0;
            wait_q    <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            wait_q    <= wait_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state, phase sequencing and strobe decode
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        wait_d    = wait_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        sel       = 1'b0;
        rd        = 1'b0;
        ld_ir     = 1'b0;
        inc_pc    = 1'b0;
        ld_ac     = 1'b0;
        wr        = 1'b0;
        ld_pc     = 1'b0;
        data_e    = 1'b0;
        halt      = (state_q == HALT);

        case (state_q)
            RUN: begin
                case (phase_q)
                    3'd0: sel = 1'b1;
                    3'd1: begin
                        sel = 1'b1;
                        rd  = 1'b1;
                    end
                    3'd2, 3'd3: begin
                        sel   = 1'b1;
                        rd    = 1'b1;
                        ld_ir = 1'b1;
                    end
                    3'd4: begin
                        inc_pc = 1'b1;
                        halt   = (opcode == OP_HLT);
                    end
                    3'd5: rd = aluop;
                    3'd6: begin
                        rd     = aluop;
                        inc_pc = (opcode == OP_SKZ) && zero;
                        ld_pc  = (opcode == OP_JMP);
                        data_e = (opcode == OP_STO);
                    end
                    default: begin
                        rd     = aluop;
                        ld_ac  = aluop;
                        ld_pc  = (opcode == OP_JMP);
                        wr     = (opcode == OP_STO);
                        data_e = (opcode == OP_STO);
                    end
                endcase

                if (stall_phase && !mem_ready) begin
                    // Hold the phase; give up after MAX_WAIT+1 not-ready cycles
                    if (wait_q == WAIT_W'(MAX_WAIT)) begin
                        state_d   = HALT;
                        timeout_d = 1'b1;
                        wait_d    = '0;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end else if ((phase_q == 3'd4) && (opcode == OP_HLT)) begin
                    state_d = HALT;
                end else begin
                    wait_d  = '0;
                    phase_d = phase_q + 3'd1;
                    if (phase_q == 3'd7) begin
                        cnt_d = cnt_q + CNT_W'(1);
`ifdef SEQ_STEP_EN
                        // Pause with phase frozen at 7; start resumes at phase 0
                        if (step_mode) begin
                            state_d = PAUSE;
                            phase_d = phase_q;
                        end
`endif
                    end
                end
            end
            default: begin
                // IDLE, HALT and PAUSE: strobes off, phase frozen until start
                if (start) begin
                    state_d   = RUN;
                    phase_d   = 3'd0;
                    wait_d    = '0;
                    timeout_d = 1'b0;
                end
            end
        endcase
    end

endmodule
